// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: FSM states, default
// vectors and the instruction-memory address check.
package cpu_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_0004;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    // A fetch address is usable only if word aligned and inside the memory.
    function automatic logic good_addr(input logic [31:0] a, input logic [31:0] depth);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < depth);
    endfunction

endpackage

// File: rtl/if_fetch_pc_next.sv
// Next-PC priority mux and next-state logic for the fetch stage, including the
// fetch-address range check.
module pc_next
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
    parameter int          IMEM_DEPTH = 2048
) (
    input  state_t      state,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc,
    output logic [31:0] pc_nxt,
    output state_t      state_nxt,
    output logic        advance,
    output logic        squash
);

    localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

    logic [31:0] pc_plus4;
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_nxt    = pc;
        state_nxt = state;
        advance   = 1'b0;
        squash    = 1'b0;
        case (state)
            BOOT: begin
                if (exc) begin
                    pc_nxt    = EXC_VEC;
                    state_nxt = RUN;
                end else begin
                    state_nxt = good_addr(pc, DEPTH) ? RUN : FAULT;
                end
            end
            RUN: begin
                if (exc) begin
                    pc_nxt = EXC_VEC;
                    squash = 1'b1;
                end else if (redirect) begin
                    // Redirect beats stall so a taken branch is never dropped.
                    pc_nxt = redirect_pc;
                    squash = 1'b1;
                    if (!good_addr(redirect_pc, DEPTH)) state_nxt = FAULT;
                end else if (!stall) begin
                    pc_nxt  = pc_plus4;
                    advance = 1'b1;
                    if (!good_addr(pc_plus4, DEPTH)) state_nxt = FAULT;
                end
            end
            FAULT: begin
                if (exc) begin
                    pc_nxt    = EXC_VEC;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = FAULT;
            end
        endcase
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, reads the instruction memory and
// captures the returned word plus its PC into the IF/ID register.
module if_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
    parameter int          IMEM_DEPTH = 2048
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               exc,
    output logic [31:0]        im_a,
    output logic               im_r,
    input  logic [INSTR_W-1:0] im_rd,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc4,
    output logic [INSTR_W-1:0] if_instr,
    output logic               if_valid,
    output logic               fetch_fault,
    output logic [31:0]        fetch_cnt
);

    state_t             state_reg, state_next;
    logic [31:0]        pc_reg, pc_next_val;
    logic               advance, squash;
    logic [31:0]        if_pc_reg, if_pc4_reg, fetch_cnt_reg;
    logic [INSTR_W-1:0] if_instr_reg;
    logic               if_valid_reg, fault_reg;

    pc_next #(
        .EXC_VEC    (EXC_VEC),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_pc_next (
        .state       (state_reg),
        .pc          (pc_reg),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc         (exc),
        .pc_nxt      (pc_next_val),
        .state_nxt   (state_next),
        .advance     (advance),
        .squash      (squash)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_PC;
            if_pc_reg     <= 32'h0;
            if_pc4_reg    <= 32'h0;
            if_instr_reg  <= '0;
            if_valid_reg  <= 1'b0;
            fault_reg     <= 1'b0;
            fetch_cnt_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next_val;
            // The word at pc is still delivered even when pc+4 falls off the end.
            if (advance) begin
                if_instr_reg  <= im_rd;
                if_pc_reg     <= pc_reg;
                if_pc4_reg    <= pc_reg + 32'd4;
                if_valid_reg  <= 1'b1;
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end else if (squash || state_reg != RUN) begin
                if_valid_reg <= 1'b0;
            end
            if (exc)                     fault_reg <= 1'b0;
            else if (state_next == FAULT) fault_reg <= 1'b1;
        end
    end

    assign im_a        = pc_reg;
    assign im_r        = (state_reg == RUN);
    assign if_pc       = if_pc_reg;
    assign if_pc4      = if_pc4_reg;
    assign if_instr    = if_instr_reg;
    assign if_valid    = if_valid_reg;
    assign fetch_fault = fault_reg;
    assign fetch_cnt   = fetch_cnt_reg;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed steps push hand-computed expectations,
// a monitor pops and compares them on the falling edge.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, exc;
    logic [31:0] redirect_pc;
    logic [31:0] im_a, im_rd, if_pc, if_pc4, if_instr, fetch_cnt;
    logic        im_r, if_valid, fetch_fault;

    always #5 clk = ~clk;

    // Memory model: the word stored at address A is ~A.
    assign im_rd = ~im_a;

    if_fetch #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VEC    (32'h0000_0004),
        .IMEM_DEPTH (2048)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc         (exc),
        .im_a        (im_a),
        .im_r        (im_r),
        .im_rd       (im_rd),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .if_instr    (if_instr),
        .if_valid    (if_valid),
        .fetch_fault (fetch_fault),
        .fetch_cnt   (fetch_cnt)
    );

    // mode 0: IF/ID payload not checked; 1: payload from pc; 2: payload all zero
    typedef struct {
        int unsigned due;
        logic [31:0] a;
        logic        r;
        logic        v;
        logic [31:0] pc;
        logic        ff;
        logic [31:0] cnt;
        int          mode;
    } exp_t;

    exp_t        sb[$];
    string       nm_q[$];
    int unsigned cyc_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    event        chk_ev;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin : monitor
        exp_t  e;
        string nm;
        logic  ok;
        forever begin
            @(negedge clk or chk_ev);
            while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
                e  = sb.pop_front();
                nm = nm_q.pop_front();
                ok = (im_a == e.a) && (im_r == e.r) && (if_valid == e.v) &&
                     (fetch_fault == e.ff) && (fetch_cnt == e.cnt);
                if (e.mode == 1)
                    ok = ok && (if_pc == e.pc) && (if_pc4 == e.pc + 32'd4) && (if_instr == ~e.pc);
                if (e.mode == 2)
                    ok = ok && (if_pc == 32'h0) && (if_pc4 == 32'h0) && (if_instr == 32'h0);
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL %s: got a=%h r=%b v=%b pc=%h pc4=%h ins=%h ff=%b cnt=%0d; want a=%h r=%b v=%b pc=%h ff=%b cnt=%0d mode=%0d",
                             nm, im_a, im_r, if_valid, if_pc, if_pc4, if_instr, fetch_fault, fetch_cnt,
                             e.a, e.r, e.v, e.pc, e.ff, e.cnt, e.mode);
                end else begin
                    $display("ok   %s: a=%h r=%b v=%b if_pc=%h ff=%b cnt=%0d",
                             nm, im_a, im_r, if_valid, if_pc, fetch_fault, fetch_cnt);
                end
            end
        end
    end

    task automatic push(input string nm, input int unsigned due, input logic [31:0] a, input logic r,
                        input logic v, input logic [31:0] pc, input logic ff, input logic [31:0] cnt,
                        input int mode);
        exp_t e;
        e.due = due; e.a = a; e.r = r; e.v = v; e.pc = pc; e.ff = ff; e.cnt = cnt; e.mode = mode;
        sb.push_back(e);
        nm_q.push_back(nm);
    endtask

    // Apply inputs for the next rising edge and expect the given state after it.
    task automatic cyc(input string nm, input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ex, input logic [31:0] a, input logic r, input logic v,
                       input logic [31:0] pc, input logic ff, input logic [31:0] cnt, input int mode);
        stall = st; redirect = rd; redirect_pc = rpc; exc = ex;
        push(nm, cyc_cnt + 1, a, r, v, pc, ff, cnt, mode);
        @(posedge clk);
        #1;
    endtask

    task automatic now_chk(input string nm, input logic [31:0] a, input logic r, input logic v,
                           input logic [31:0] pc, input logic ff, input logic [31:0] cnt, input int mode);
        push(nm, cyc_cnt, a, r, v, pc, ff, cnt, mode);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; exc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        now_chk("reset", 32'h0, 0, 0, 32'h0, 0, 0, 2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        now_chk("boot", 32'h0, 0, 0, 32'h0, 0, 0, 2);
        //   name                st rd rpc           ex  im_a          r  v  if_pc         ff cnt mode
        cyc("boot_to_run",      0, 0, 32'h0,        0,  32'h0,        1, 0, 32'h0,        0, 0,  2);
        cyc("fetch_0",          0, 0, 32'h0,        0,  32'h4,        1, 1, 32'h0,        0, 1,  1);
        cyc("fetch_4",          0, 0, 32'h0,        0,  32'h8,        1, 1, 32'h4,        0, 2,  1);
        cyc("stall_1",          1, 0, 32'h0,        0,  32'h8,        1, 1, 32'h4,        0, 2,  1);
        cyc("stall_2",          1, 0, 32'h0,        0,  32'h8,        1, 1, 32'h4,        0, 2,  1);
        cyc("fetch_8",          0, 0, 32'h0,        0,  32'hC,        1, 1, 32'h8,        0, 3,  1);
        cyc("fetch_c",          0, 0, 32'h0,        0,  32'h10,       1, 1, 32'hC,        0, 4,  1);
        cyc("redir_40",         0, 1, 32'h40,       0,  32'h40,       1, 0, 32'h0,        0, 4,  0);
        cyc("fetch_40",         0, 0, 32'h0,        0,  32'h44,       1, 1, 32'h40,       0, 5,  1);
        cyc("redir_stall_60",   1, 1, 32'h60,       0,  32'h60,       1, 0, 32'h0,        0, 5,  0);
        cyc("fetch_60",         0, 0, 32'h0,        0,  32'h64,       1, 1, 32'h60,       0, 6,  1);
        cyc("redir_misaligned", 0, 1, 32'h42,       0,  32'h42,       0, 0, 32'h0,        1, 6,  0);
        for (int i = 0; i < 5; i++)
            cyc($sformatf("fault_hold_%0d", i), (i == 3), (i == 1), 32'h100, 0,
                32'h42, 0, 0, 32'h0, 1, 6, 0);
        cyc("exc_from_fault",   0, 0, 32'h0,        1,  32'h4,        1, 0, 32'h0,        0, 6,  0);
        cyc("fetch_4b",         0, 0, 32'h0,        0,  32'h8,        1, 1, 32'h4,        0, 7,  1);
        cyc("redir_range",      0, 1, 32'h2000,     0,  32'h2000,     0, 0, 32'h0,        1, 7,  0);
        cyc("fault_hold_range", 0, 0, 32'h0,        0,  32'h2000,     0, 0, 32'h0,        1, 7,  0);
        cyc("exc_from_range",   0, 0, 32'h0,        1,  32'h4,        1, 0, 32'h0,        0, 7,  0);
        cyc("fetch_4c",         0, 0, 32'h0,        0,  32'h8,        1, 1, 32'h4,        0, 8,  1);
        cyc("redir_last_word",  0, 1, 32'h1FFC,     0,  32'h1FFC,     1, 0, 32'h0,        0, 8,  0);
        cyc("fetch_last_word",  0, 0, 32'h0,        0,  32'h2000,     0, 1, 32'h1FFC,     1, 9,  1);
        cyc("fault_after_last", 0, 0, 32'h0,        0,  32'h2000,     0, 0, 32'h0,        1, 9,  0);
        cyc("exc_after_last",   0, 0, 32'h0,        1,  32'h4,        1, 0, 32'h0,        0, 9,  0);
        cyc("redir_20",         0, 1, 32'h20,       0,  32'h20,       1, 0, 32'h0,        0, 9,  0);
        cyc("exc_beats_redir",  0, 1, 32'h80,       1,  32'h4,        1, 0, 32'h0,        0, 9,  0);
        cyc("fetch_4d",         0, 0, 32'h0,        0,  32'h8,        1, 1, 32'h4,        0, 10, 1);
        cyc("redir_30",         0, 1, 32'h30,       0,  32'h30,       1, 0, 32'h0,        0, 10, 0);
        // Assert reset between clock edges and check before the next rising edge.
        @(negedge clk);
        #1;
        redirect = 1'b0;
        rst_n = 1'b0;
        #1;
        now_chk("async_reset", 32'h0, 0, 0, 32'h0, 0, 0, 2);
        -> chk_ev;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        now_chk("boot_again", 32'h0, 0, 0, 32'h0, 0, 0, 2);
        cyc("boot_to_run_2",    0, 0, 32'h0,        0,  32'h0,        1, 0, 32'h0,        0, 0,  2);
        cyc("fetch_0_again",    0, 0, 32'h0,        0,  32'h4,        1, 1, 32'h0,        0, 1,  1);
        cyc("fetch_4_again",    0, 0, 32'h0,        0,  32'h8,        1, 1, 32'h4,        0, 2,  1);
        repeat (2) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
